// File: rtl/fc_pkg.sv
// Shared state encoding and default layer geometry for the FC layer sequencer slice.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_DONE    = 3'd5
  } fc_state_t;

  localparam int INNEURON_DEF            = 8;
  localparam int OUTNEURON_DEF           = 4;
  localparam int PO_DEF                  = 2;
  localparam int DATA_WIDTH_FC_DEF       = 16;
  localparam int ACCUM_DATA_WIDTH_FC_DEF = 32;
  localparam int ADDR_W_DEF              = 3;
  localparam int MAC_LAT_DEF             = 2;

  // Counter width that can hold its terminal value without wrapping.
  function automatic int cnt_w(input int terminal);
    return $clog2(terminal) + 1;
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Load and result streaming handshakes of the FC layer sequencer.
interface fc_layer_sequencer_if
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH_FC       = DATA_WIDTH_FC_DEF,
  parameter int ACCUM_DATA_WIDTH_FC = ACCUM_DATA_WIDTH_FC_DEF
) ();

  logic                           load_valid;
  logic                           load_ready;
  logic [DATA_WIDTH_FC-1:0]       load_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [ACCUM_DATA_WIDTH_FC-1:0] out_data;

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, out_data
  );

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, out_data
  );

endinterface

// File: rtl/fc_result_serializer.sv
// Captures PO accumulator lanes at the end of FLUSH and streams them out lane 0 first.
module fc_result_serializer
  import fc_pkg::*;
#(
  parameter int PO                  = PO_DEF,
  parameter int ACCUM_DATA_WIDTH_FC = ACCUM_DATA_WIDTH_FC_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              capture,
  input  logic                              active,
  input  logic                              out_ready,
  input  logic [PO*ACCUM_DATA_WIDTH_FC-1:0] acc_in,
  output logic                              out_valid,
  output logic signed [ACCUM_DATA_WIDTH_FC-1:0] out_data,
  output logic                              lane_done
);

  localparam int IDX_W = cnt_w(PO);

  logic signed [ACCUM_DATA_WIDTH_FC-1:0] lanes_p0 [PO];
  logic [IDX_W-1:0]                      idx;
  logic                                  hs;
  logic                                  idx_last;

  assign hs        = active && out_ready;
  assign idx_last  = (idx == IDX_W'(PO - 1));
  assign lane_done = hs && idx_last;
  assign out_valid = active;

  // Capture stage: lanes are held until the next group's FLUSH overwrites them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PO; i++) lanes_p0[i] <= '0;
      idx <= '0;
    end else if (capture) begin
      for (int i = 0; i < PO; i++)
        lanes_p0[i] <= acc_in[i*ACCUM_DATA_WIDTH_FC +: ACCUM_DATA_WIDTH_FC];
      idx <= '0;
    end else if (hs) begin
      idx <= idx_last ? '0 : idx + IDX_W'(1);
    end
  end

  always_comb begin
    out_data = '0;
    if (active) begin
      for (int i = 0; i < PO; i++)
        if (idx == IDX_W'(i)) out_data = lanes_p0[i];
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Layer control for a fully connected layer: loads inputs, drives pairwise reads into the MAC, streams results.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int INNEURON            = INNEURON_DEF,
  parameter int OUTNEURON           = OUTNEURON_DEF,
  parameter int PO                  = PO_DEF,
  parameter int DATA_WIDTH_FC       = DATA_WIDTH_FC_DEF,
  parameter int ACCUM_DATA_WIDTH_FC = ACCUM_DATA_WIDTH_FC_DEF,
  parameter int ADDR_W              = ADDR_W_DEF,
  parameter int MAC_LAT             = MAC_LAT_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  fc_layer_sequencer_if.slave               bus,
  output logic                              nb_wr_en,
  output logic [ADDR_W-1:0]                 nb_wr_addr,
  output logic [DATA_WIDTH_FC-1:0]          nb_wr_data,
  output logic                              nb_rd_en,
  output logic [ADDR_W-1:0]                 nb_rd_addr_a,
  output logic [ADDR_W-1:0]                 nb_rd_addr_b,
  output logic                              mac_en,
  output logic                              mac_sload,
  input  logic [PO*ACCUM_DATA_WIDTH_FC-1:0] acc_in,
  output logic                              busy,
  output logic                              done
);

  localparam int NPAIR  = INNEURON / 2;
  localparam int NGROUP = OUTNEURON / PO;
  localparam int LD_W   = cnt_w(INNEURON);
  localparam int K_W    = cnt_w(NPAIR);
  localparam int G_W    = cnt_w(NGROUP);
  localparam int F_W    = cnt_w(MAC_LAT);

  fc_state_t        state, state_nxt;
  logic [LD_W-1:0]  load_cnt;
  logic [K_W-1:0]   k_cnt;
  logic [G_W-1:0]   group_cnt;
  logic [F_W-1:0]   flush_cnt;
  logic             load_hs, k_last, flush_last, group_last;
  logic             capture, active, lane_done;
  logic             rd_en_p1, sload_p1;
  logic             out_valid_w;
  logic [ACCUM_DATA_WIDTH_FC-1:0] out_data_w;

  assign load_hs    = (state == ST_LOAD) && bus.load_valid;
  assign k_last     = (k_cnt == K_W'(NPAIR - 1));
  assign flush_last = (flush_cnt == F_W'(MAC_LAT));
  assign group_last = (group_cnt == G_W'(NGROUP - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.load_ready = 1'b0;
    nb_rd_en       = 1'b0;
    capture        = 1'b0;
    active         = 1'b0;
    done           = 1'b0;
    busy           = (state != ST_IDLE);
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        bus.load_ready = 1'b1;
        if (load_hs && load_cnt == LD_W'(INNEURON - 1)) state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        nb_rd_en = 1'b1;
        if (k_last) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        capture = flush_last;
        if (flush_last) state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        active = 1'b1;
        if (lane_done) state_nxt = group_last ? ST_DONE : ST_COMPUTE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_cnt  <= '0;
      k_cnt     <= '0;
      group_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == ST_DONE)  load_cnt <= '0;
      else if (load_hs)      load_cnt <= load_cnt + LD_W'(1);
      if (state == ST_COMPUTE) k_cnt <= k_last ? '0 : k_cnt + K_W'(1);
      if (state == ST_FLUSH)   flush_cnt <= flush_last ? '0 : flush_cnt + F_W'(1);
      if (state == ST_DONE)    group_cnt <= '0;
      else if (state == ST_OUTPUT && lane_done && !group_last)
        group_cnt <= group_cnt + G_W'(1);
    end
  end

  // Read-to-MAC stage: the neuron buffer returns data one cycle after the read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_en_p1 <= 1'b0;
      sload_p1 <= 1'b0;
    end else begin
      rd_en_p1 <= nb_rd_en;
      sload_p1 <= nb_rd_en && (k_cnt == '0);
    end
  end

  assign mac_en       = rd_en_p1;
  assign mac_sload    = sload_p1;
  assign nb_wr_en     = load_hs;
  assign nb_wr_addr   = load_hs ? ADDR_W'(load_cnt) : '0;
  assign nb_wr_data   = load_hs ? bus.load_data : '0;
  assign nb_rd_addr_a = nb_rd_en ? ADDR_W'({k_cnt, 1'b0}) : '0;
  assign nb_rd_addr_b = nb_rd_en ? ADDR_W'({k_cnt, 1'b1}) : '0;

  fc_result_serializer #(
    .PO                  (PO),
    .ACCUM_DATA_WIDTH_FC (ACCUM_DATA_WIDTH_FC)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .capture   (capture),
    .active    (active),
    .out_ready (bus.out_ready),
    .acc_in    (acc_in),
    .out_valid (out_valid_w),
    .out_data  (out_data_w),
    .lane_done (lane_done)
  );

  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scenario bench for fc_layer_sequencer: expected results queued when acc_in is driven, checked on output handshakes.
module tb_fc_layer_sequencer;

  localparam int INN     = 8;
  localparam int OUTN    = 4;
  localparam int PO      = 2;
  localparam int DW      = 16;
  localparam int AW      = 32;
  localparam int ADDR_W  = 3;
  localparam int MAC_LAT = 2;
  localparam int NPAIR   = INN / 2;
  localparam int NGROUP  = OUTN / PO;
  localparam int CAP     = NPAIR + MAC_LAT;
  localparam int LAT     = NPAIR + 1 + MAC_LAT;

  logic              clock;
  logic              reset;
  logic              start;
  logic              nb_wr_en;
  logic [ADDR_W-1:0] nb_wr_addr;
  logic [DW-1:0]     nb_wr_data;
  logic              nb_rd_en;
  logic [ADDR_W-1:0] nb_rd_addr_a;
  logic [ADDR_W-1:0] nb_rd_addr_b;
  logic              mac_en;
  logic              mac_sload;
  logic [PO*AW-1:0]  acc_in;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [AW-1:0] sb[$];

  fc_layer_sequencer_if #(.DATA_WIDTH_FC(DW), .ACCUM_DATA_WIDTH_FC(AW)) bus ();

  fc_layer_sequencer #(
    .INNEURON(INN), .OUTNEURON(OUTN), .PO(PO), .DATA_WIDTH_FC(DW),
    .ACCUM_DATA_WIDTH_FC(AW), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .nb_wr_en     (nb_wr_en),
    .nb_wr_addr   (nb_wr_addr),
    .nb_wr_data   (nb_wr_data),
    .nb_rd_en     (nb_rd_en),
    .nb_rd_addr_a (nb_rd_addr_a),
    .nb_rd_addr_b (nb_rd_addr_b),
    .mac_en       (mac_en),
    .mac_sload    (mac_sload),
    .acc_in       (acc_in),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h55AA;
    bus.out_ready  = 1'b1;
    acc_in = '1;
    #3;
    total++;
    if ({busy, done, bus.load_ready, bus.out_valid, bus.out_data, nb_wr_en, nb_wr_addr, nb_wr_data,
         nb_rd_en, nb_rd_addr_a, nb_rd_addr_b, mac_en, mac_sload} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b wr=%b rd=%b out_valid=%b out_data=%h required all zero",
               busy, nb_wr_en, nb_rd_en, bus.out_valid, bus.out_data);
    end
    cyc();
    cyc();
    reset = 1'b0;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b0;
    cyc();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy got=%b required=0", busy);
    end
  endtask

  // Start on the next edge, then load INN words; rnd inserts bubbles and random data.
  task automatic load_layer(input bit rnd);
    int i;
    logic v;
    logic [DW-1:0] d;
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || bus.load_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_to_load busy=%b load_ready=%b required 1/1", busy, bus.load_ready);
    end
    i = 0;
    for (int n = 0; n < 64 && i < INN; n++) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      d = rnd ? DW'($urandom) : DW'(i + 1);
      bus.load_valid = v;
      bus.load_data  = d;
      #1;
      total++;
      if (nb_wr_en !== v) begin
        bad++;
        $display("FAIL load_wr_en word=%0d got=%b required=%b", i, nb_wr_en, v);
      end
      if (v) begin
        total++;
        if (nb_wr_addr !== ADDR_W'(i) || nb_wr_data !== d) begin
          bad++;
          $display("FAIL load_write addr/data got=%0d/%h required=%0d/%h", nb_wr_addr, nb_wr_data, i, d);
        end
        i++;
      end
      cyc();
    end
    bus.load_valid = 1'b0;
    total++;
    if (i != INN) begin
      bad++;
      $display("FAIL load_count got=%0d required=%0d", i, INN);
    end
    #1;
    total++;
    if (bus.load_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_ready_drop got=%b required=0", bus.load_ready);
    end
  endtask

  // Runs one group from COMPUTE entry to the first OUTPUT cycle; acc_in is valid only in the capture cycle.
  task automatic run_group(input logic [AW-1:0] l0, input logic [AW-1:0] l1, input bit spur);
    logic [ADDR_W-1:0] ea, eb;
    for (int c = 0; c <= LAT; c++) begin
      acc_in = (c == CAP) ? {l1, l0} : {$urandom, $urandom};
      bus.load_valid = spur && (c < NPAIR);
      #1;
      total++;
      if (nb_rd_en !== (c < NPAIR)) begin
        bad++;
        $display("FAIL rd_en cycle=%0d got=%b required=%b", c, nb_rd_en, (c < NPAIR));
      end
      if (c < NPAIR) begin
        ea = ADDR_W'(2 * c);
        eb = ADDR_W'(2 * c + 1);
        total++;
        if (nb_rd_addr_a !== ea || nb_rd_addr_b !== eb) begin
          bad++;
          $display("FAIL rd_addr cycle=%0d got=(%0d,%0d) required=(%0d,%0d)", c, nb_rd_addr_a, nb_rd_addr_b, ea, eb);
        end
      end
      total++;
      if (mac_en !== (c >= 1 && c <= NPAIR)) begin
        bad++;
        $display("FAIL mac_en cycle=%0d got=%b required=%b", c, mac_en, (c >= 1 && c <= NPAIR));
      end
      total++;
      if (mac_sload !== (c == 1)) begin
        bad++;
        $display("FAIL mac_sload cycle=%0d got=%b required=%b", c, mac_sload, (c == 1));
      end
      total++;
      if (bus.out_valid !== (c == LAT)) begin
        bad++;
        $display("FAIL out_valid_latency cycle=%0d got=%b required=%b", c, bus.out_valid, (c == LAT));
      end
      if (spur && c < NPAIR) begin
        total++;
        if (nb_wr_en !== 1'b0 || bus.load_ready !== 1'b0) begin
          bad++;
          $display("FAIL spurious_load cycle=%0d wr_en=%b load_ready=%b required 0/0", c, nb_wr_en, bus.load_ready);
        end
      end
      if (c == CAP) begin
        sb.push_back(l0);
        sb.push_back(l1);
      end
      if (c < LAT) cyc();
    end
    bus.load_valid = 1'b0;
  endtask

  // Holds out_ready low for stall cycles, then accepts PO lanes on consecutive cycles.
  task automatic drain(input int stall, input bit poke_start);
    logic [AW-1:0] exp;
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0;
      start = poke_start;
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== sb[0] || busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold cycle=%0d got valid=%b data=%h required valid=1 data=%h", s, bus.out_valid, bus.out_data, sb[0]);
      end
      cyc();
    end
    start = 1'b0;
    for (int l = 0; l < PO; l++) begin
      bus.out_ready = 1'b1;
      #1;
      exp = sb.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
        bad++;
        $display("FAIL result lane=%0d got valid=%b data=%h required valid=1 data=%h", l, bus.out_valid, bus.out_data, exp);
      end
      cyc();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic finish_layer(input bit poke_start);
    start = poke_start;
    #1;
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse got done=%b busy=%b required 1/1", done, busy);
    end
    cyc();
    start = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.load_ready !== 1'b0) begin
      bad++;
      $display("FAIL after_done got done=%b busy=%b load_ready=%b required 0/0/0", done, busy, bus.load_ready);
    end
  endtask

  task automatic test_load_and_compute();
    load_layer(1'b0);
    run_group(32'h1111_0000, 32'h2222_0001, 1'b0);
    drain(0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_group(32'h0000_000A, 32'h0000_000B, 1'b0);
    drain(5, 1'b0);
    finish_layer(1'b0);
  endtask

  task automatic test_full_layer();
    int snap;
    snap = done_cnt;
    load_layer(1'b1);
    for (int g = 0; g < NGROUP; g++) begin
      run_group($urandom, $urandom, 1'b0);
      drain($urandom_range(0, 3), 1'b0);
    end
    finish_layer(1'b0);
    total++;
    if (done_cnt - snap != 1) begin
      bad++;
      $display("FAIL done_count got=%0d required=1", done_cnt - snap);
    end
  endtask

  task automatic test_spurious();
    load_layer(1'b0);
    for (int g = 0; g < NGROUP; g++) begin
      run_group($urandom, $urandom, 1'b1);
      drain(3, 1'b1);
    end
    finish_layer(1'b1);
  endtask

  task automatic test_abort();
    int snap;
    load_layer(1'b0);
    run_group($urandom, $urandom, 1'b0);
    drain(0, 1'b0);
    cyc();
    cyc();
    snap = done_cnt;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, bus.load_ready, bus.out_valid, bus.out_data, nb_wr_en, nb_rd_en,
         nb_rd_addr_a, nb_rd_addr_b, mac_en, mac_sload} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got busy=%b rd=%b mac_en=%b sload=%b required all zero", busy, nb_rd_en, mac_en, mac_sload);
    end
    sb.delete();
    cyc();
    reset = 1'b0;
    load_layer(1'b0);
    total++;
    if (done_cnt != snap) begin
      bad++;
      $display("FAIL abort_no_done got=%0d required=0", done_cnt - snap);
    end
    for (int g = 0; g < NGROUP; g++) begin
      run_group($urandom, $urandom, 1'b0);
      drain(1, 1'b0);
    end
    finish_layer(1'b0);
    total++;
    if (done_cnt - snap != 1) begin
      bad++;
      $display("FAIL rerun_done_count got=%0d required=1", done_cnt - snap);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_compute();
    test_backpressure();
    test_full_layer();
    test_spurious();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
